sha256_ctrl: RTL
================

SHA256_CTRL -- requirements
Module: sha256_ctrl

Interface
REQ-001 Parameter: ROUNDS, default 64, number of compression rounds per 512-bit block.
REQ-002 i_clk  input  1  rising-edge clock.
REQ-003 i_rst  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a 512-bit block is presented on the datapath.
REQ-005 in_last  input  1  the presented block is the final block of the message; qualified by in_valid.
REQ-006 in_ready  output  1  the controller can accept a block.
REQ-007 abort  input  1  synchronous soft clear of the current message.
REQ-008 clr_i  output  1  clears the external 8-bit round counter.
REQ-009 cnt_i_en  output  1  increments the external round counter.
REQ-010 i  input  8  current round index, read back from the round counter.
REQ-011 ld_block  output  1  loads W[0..15] from the input block.
REQ-012 init_hash  output  1  loads H0..H7 with the FIPS 180-4 initial values.
REQ-013 ld_work  output  1  loads a..h from H0..H7.
REQ-014 rnd_en  output  1  executes compression round i.
REQ-015 w_sel  output  1  1 = use W[i] directly (i<16); 0 = use the scheduled word.
REQ-016 upd_hash  output  1  sets H += a..h.
REQ-017 out_valid  output  1  digest is valid.
REQ-018 out_ready  input  1  the consumer accepts the digest.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, ROUND, UPDATE and DONE; all outputs SHALL be combinational decodes of the state, i and the flags.
REQ-021 IDLE SHALL assert in_ready; on in_valid&&in_ready it SHALL assert ld_block and clr_i, assert init_hash iff first_blk=1, capture in_last into last_blk, clear first_blk and go to LOAD.
REQ-022 LOAD SHALL assert ld_work for exactly one cycle and then go to ROUND.
REQ-023 ROUND SHALL assert rnd_en and cnt_i_en every cycle and set w_sel=(i<16); when i>=ROUNDS-1 it SHALL go to UPDATE, so it lasts exactly ROUNDS cycles from i=0.
REQ-024 UPDATE SHALL assert upd_hash and clr_i for one cycle, then go to DONE if last_blk=1, otherwise to IDLE.
REQ-025 DONE SHALL hold out_valid=1 until out_ready=1; on that handshake it SHALL set first_blk=1 and go to IDLE.
REQ-026 Latency: acceptance at cycle 0, LOAD at 1, ROUND at 2..ROUNDS+1, UPDATE at ROUNDS+2, and out_valid from ROUNDS+3 (cycle 67 at default).
REQ-027 in_valid outside IDLE SHALL be ignored (in_ready=0), and out_ready outside DONE SHALL be ignored.
REQ-028 abort SHALL win over every event in the same cycle: it pulses clr_i, sets first_blk=1, deasserts all other strobes, and the next state is IDLE.
REQ-029 If i>ROUNDS-1 on entry to ROUND (corrupt counter), the FSM SHALL still leave to UPDATE on the first cycle.
REQ-030 rnd_en, ld_work, ld_block and upd_hash SHALL be mutually exclusive in every cycle.

Reset
REQ-031 i_rst low SHALL immediately force state=IDLE, first_blk=1 and last_blk=0.
REQ-032 During reset in_ready=0, busy=0, out_valid=0 and all strobes SHALL be 0; in_ready SHALL rise the first cycle after release.
REQ-033 Reset mid-ROUND SHALL discard the block; the external counter is reset by the same i_rst.

Structure
REQ-034 Package sha256_pkg SHALL hold ROUNDS, the counter width (8), the state enum and the H0..H7 init constants.
REQ-035 No sub-module SHALL be used; the round counter sha256_counter_i SHALL be instantiated beside sha256_ctrl at the core top level and wired clr_i/cnt_i_en/i.

Verification
REQ-036 Single-block message (in_last=1): init_hash=1 at cycle 0, 64 rnd_en cycles with i=0..63, upd_hash at cycle 66, out_valid at cycle 67; a digest of "abc" equals ba7816bf...f20015ad.
REQ-037 Two-block message: init_hash=1 only for block 1, in_ready returns after the first UPDATE, out_valid only after the second UPDATE; a 56-byte test vector gives 248d6a61...19db06c1.
REQ-038 out_ready held low for 10 cycles in DONE: out_valid stays 1 and in_ready stays 0; releasing out_ready returns to IDLE the next cycle.
REQ-039 abort asserted at i=30, together with in_valid: next cycle IDLE, i=0, and the next accepted block asserts init_hash.
REQ-040 i_rst pulsed low at i=40: all outputs 0 asynchronously; after release, a fresh "abc" block gives the correct digest.
REQ-041 Assertions: w_sel==(i<16) whenever rnd_en=1; strobes one-hot-or-zero; cnt_i_en=1 only in ROUND.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 control package: round count, counter width,
// FSM state encoding and the initial hash constants.
package sha256_pkg;

    localparam int ROUNDS = 64;
    localparam int CNT_W  = 8;
    localparam int N_HASH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_UPDATE,
        ST_DONE
    } state_e;

    // FIPS 180-4 initial hash words, H0 in the lowest slot.
    localparam logic [N_HASH-1:0][31:0] H_INIT = {
        32'h5be0cd19,
        32'h1f83d9ab,
        32'h9b05688c,
        32'h510e527f,
        32'ha54ff53a,
        32'h3c6ef372,
        32'hbb67ae85,
        32'h6a09e667
    };

    function automatic logic [31:0] h_init(
        input logic [2:0] idx
    );
        return H_INIT[idx];
    endfunction

endpackage

// File: rtl/sha256_ctrl.sv
// SHA-256 block controller: sequences load, ROUNDS compression
// rounds, hash update and digest handshake for a datapath.
//
// Ports:
//   i_clk, i_rst        clock, async active-low reset
//   in_valid/in_last    block offered / it is the final block
//   in_ready            block accepted when high with in_valid
//   abort               synchronous clear of the current message
//   clr_i, cnt_i_en, i  external round counter control / readback
//   ld_block, init_hash, ld_work, rnd_en, w_sel, upd_hash
//                       datapath strobes
//   out_valid/out_ready digest handshake
//   busy                any state other than IDLE
module sha256_ctrl #(
    parameter int ROUNDS = sha256_pkg::ROUNDS
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    input  logic                         abort,
    output logic                         clr_i,
    output logic                         cnt_i_en,
    input  logic [sha256_pkg::CNT_W-1:0] i,
    output logic                         ld_block,
    output logic                         init_hash,
    output logic                         ld_work,
    output logic                         rnd_en,
    output logic                         w_sel,
    output logic                         upd_hash,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    import sha256_pkg::*;

    localparam logic [CNT_W-1:0] I_LAST   = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] I_DIRECT = CNT_W'(16);

    state_e state;
    logic   first_blk;
    logic   last_blk;
    // Low during reset and for the first edge after release, so
    // every output stays quiet until the controller is running.
    logic   run;
    logic   accept;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            first_blk <= 1'b1;
            last_blk  <= 1'b0;
            run       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (abort) begin
                state     <= ST_IDLE;
                first_blk <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state     <= ST_LOAD;
                            last_blk  <= in_last;
                            first_blk <= 1'b0;
                        end
                    end
                    ST_LOAD: begin
                        state <= ST_ROUND;
                    end
                    ST_ROUND: begin
                        // >= also exits on a corrupt counter
                        if (i >= I_LAST) begin
                            state <= ST_UPDATE;
                        end
                    end
                    ST_UPDATE: begin
                        state <= last_blk ? ST_DONE : ST_IDLE;
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            state     <= ST_IDLE;
                            first_blk <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        accept    = 1'b0;
        clr_i     = 1'b0;
        cnt_i_en  = 1'b0;
        ld_block  = 1'b0;
        init_hash = 1'b0;
        ld_work   = 1'b0;
        rnd_en    = 1'b0;
        w_sel     = 1'b0;
        upd_hash  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != ST_IDLE);
        if (run) begin
            if (abort) begin
                clr_i = 1'b1;
            end else begin
                unique case (1'b1)
                    (state == ST_IDLE): begin
                        in_ready  = 1'b1;
                        accept    = in_valid;
                        ld_block  = in_valid;
                        clr_i     = in_valid;
                        init_hash = in_valid & first_blk;
                    end
                    (state == ST_LOAD): begin
                        ld_work = 1'b1;
                    end
                    (state == ST_ROUND): begin
                        rnd_en   = 1'b1;
                        cnt_i_en = 1'b1;
                        w_sel    = (i < I_DIRECT);
                    end
                    (state == ST_UPDATE): begin
                        upd_hash = 1'b1;
                        clr_i    = 1'b1;
                    end
                    (state == ST_DONE): begin
                        out_valid = 1'b1;
                    end
                    default: begin
                        in_ready = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
